if_fetch_queue: RTL

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/core_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/if_fetch_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: reset PC and the fetch-queue entry layout.
// Widths here must match the BUS_WIDTH/INSTR_WIDTH the fetch queue is built with.
package core_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Generic FIFO with wrap-bit pointers; head visible combinationally, push/pop take effect at the edge.
// A push into a full FIFO or a pop from an empty one is ignored; flush empties it synchronously.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means every slot is in use.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch: one read per cycle into a FQ_DEPTH queue, 2-cycle fetch-to-valid, stalls on credits.
// Optional IF_PERF_CNT_EN adds saturating pop and decode-starved-cycle counters.
module if_fetch_queue
  import core_pkg::*;
#(
  parameter int BUS_WIDTH     = XLEN,
  parameter int INSTR_WIDTH   = ILEN,
  parameter int INSTR_MEM_LEN = 15,
  parameter int FQ_DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect,
  input  logic [BUS_WIDTH-1:0]     redirect_pc,
  output logic                     imem_en,
  output logic [INSTR_MEM_LEN-1:0] imem_addr,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BUS_WIDTH-1:0]     out_pc,
  output logic [INSTR_WIDTH-1:0]   out_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall_cycles
`endif
);
  localparam int CW = $clog2(FQ_DEPTH);
  localparam logic [CW+1:0] DEPTH_LIM = (CW+2)'(FQ_DEPTH);

  logic [BUS_WIDTH-1:0] fetch_pc;
  logic [BUS_WIDTH-1:0] inflight_pc;
  logic                 inflight;
  logic [CW:0]          occupancy;
  logic [CW+1:0]        pending;
  logic                 fetch_go;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  fq_entry_t            push_dat;
  fq_entry_t            head;
  logic                 unused_lsbs;

  assign unused_lsbs = ^redirect_pc[1:0];

  // Count the in-flight read as a reserved slot so the queue can never overflow.
  assign pending   = {1'b0, occupancy} + {{(CW+1){1'b0}}, inflight};
  assign fetch_go  = rst_n && !redirect && (pending < DEPTH_LIM);
  assign imem_en   = fetch_go;
  assign imem_addr = fetch_pc[INSTR_MEM_LEN+1:2];

  assign push = inflight && !redirect;
  assign pop  = out_valid && out_ready && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= BUS_WIDTH'(RESET_PC);
      inflight_pc <= '0;
      inflight    <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[BUS_WIDTH-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= fetch_go;
      if (fetch_go) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + BUS_WIDTH'(4);
      end
    end
  end

  assign push_dat.pc    = inflight_pc;
  assign push_dat.instr = imem_rdata;

  fetch_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .empty    (fifo_empty),
    .count    (occupancy)
  );

  // Storage is not reset, so mask the head while the queue is empty.
  assign out_valid = !fifo_empty;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (pop && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if (out_ready && !out_valid && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif
endmodule
